// File: rtl/fma_pipe_pkg.sv
// Shared types and helpers for the FMA micro-op pipeline.
//   rob_idx_t : ROB index (wrap flag + value), sized for the widest supported ROB
//   uop_t     : uop fields carried down the pipeline alongside the datapath
//   RM_DYN    : rounding-mode encoding that selects the CSR frm value
//   is_after  : age compare of two ROB indices with wrap-flag handling
package fma_pipe_pkg;

   // Storage widths; the pipeline zero-extends narrower ROB/pdest indices.
   localparam int ROB_MAX_W   = 16;
   localparam int PDEST_MAX_W = 16;

   localparam logic [2:0] RM_DYN = 3'h7;

   typedef struct packed {
      logic                 flag;
      logic [ROB_MAX_W-1:0] value;
   } rob_idx_t;

   typedef struct packed {
      logic                   rfWen;
      logic                   fpWen;
      logic [PDEST_MAX_W-1:0] pdest;
      rob_idx_t               robIdx;
      logic [2:0]             rm;
   } uop_t;

   // a is younger than b. Differing wrap flags invert the plain value compare.
   function automatic logic is_after(input rob_idx_t a, input rob_idx_t b);
      return (a.flag ^ b.flag) ^ (a.value > b.value);
   endfunction

endpackage

// File: rtl/fma_flush_chk.sv
// Combinational flush decision for one uop against a branch/exception redirect.
//   uop_rob        : ROB index of the uop under test
//   redirect_valid : redirect present this cycle
//   redirect_level : 1 = the redirecting uop itself is also squashed
//   redirect_rob   : ROB index of the redirect
//   flush          : uop must be discarded
module fma_flush_chk
   import fma_pipe_pkg::*;
(
   input  rob_idx_t uop_rob,
   input  logic     redirect_valid,
   input  logic     redirect_level,
   input  rob_idx_t redirect_rob,
   output logic     flush
);

   assign flush = redirect_valid &
                  (is_after(uop_rob, redirect_rob) |
                   (redirect_level & (uop_rob == redirect_rob)));

endmodule

// File: rtl/fma_uop_pipe.sv
// Control/uop pipeline that runs in lockstep with an external FMA datapath.
// Carries valid + uop fields through LATENCY stages under a single global
// stall, squashes redirected uops at every stage, resolves the dynamic
// rounding mode at the input and registers the datapath result at the end.
//   clock, reset              : clock, synchronous active-high reset
//   in_valid/in_ready + in_*  : uop issue handshake and fields
//   frm, rm_out               : CSR rounding mode, resolved mode for the datapath
//   redirect_*                : pipeline flush request
//   stage_en                  : per-stage load enable for the external datapath
//   res_data, res_fflags      : datapath result, presented one cycle before output
//   out_valid/out_ready + out_*: registered result uop handshake
module fma_uop_pipe
   import fma_pipe_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int ROB_W   = 5,
   parameter int PDEST_W = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_rfWen,
   input  logic               in_fpWen,
   input  logic [2:0]         in_rm,
   input  logic [PDEST_W-1:0] in_pdest,
   input  logic               in_robIdx_flag,
   input  logic [ROB_W-1:0]   in_robIdx_value,
   input  logic [2:0]         frm,
   output logic [2:0]         rm_out,
   input  logic               redirect_valid,
   input  logic               redirect_robIdx_flag,
   input  logic               redirect_level,
   input  logic [ROB_W-1:0]   redirect_robIdx_value,
   output logic [LATENCY-1:0] stage_en,
   input  logic [63:0]        res_data,
   input  logic [4:0]         res_fflags,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_rfWen,
   output logic               out_fpWen,
   output logic [PDEST_W-1:0] out_pdest,
   output logic               out_robIdx_flag,
   output logic [ROB_W-1:0]   out_robIdx_value,
   output logic [63:0]        out_data,
   output logic [4:0]         out_fflags
);

   logic               advance;
   uop_t               in_uop;
   rob_idx_t           redirect_rob;
   logic               in_flush;
   logic [LATENCY-1:0] stg_flush;

   logic [LATENCY-1:0] vld_d, vld_q;
   uop_t               uop_d [LATENCY];
   uop_t               uop_q [LATENCY];
   logic [63:0]        data_d, data_q;
   logic [4:0]         fflags_d, fflags_q;

   // Input stage: resolve rounding mode and widen indices into the uop record
   always_comb begin
      rm_out = (in_rm != RM_DYN) ? in_rm : frm;

      in_uop                             = '0;
      in_uop.rfWen                       = in_rfWen;
      in_uop.fpWen                       = in_fpWen;
      in_uop.pdest[PDEST_W-1:0]          = in_pdest;
      in_uop.robIdx.flag                 = in_robIdx_flag;
      in_uop.robIdx.value[ROB_W-1:0]     = in_robIdx_value;
      in_uop.rm                          = rm_out;

      redirect_rob                       = '0;
      redirect_rob.flag                  = redirect_robIdx_flag;
      redirect_rob.value[ROB_W-1:0]      = redirect_robIdx_value;
   end

   fma_flush_chk u_in_flush (
      .uop_rob        (in_uop.robIdx),
      .redirect_valid (redirect_valid),
      .redirect_level (redirect_level),
      .redirect_rob   (redirect_rob),
      .flush          (in_flush)
   );

   for (genvar g = 0; g < LATENCY; g++) begin : g_stg_flush
      fma_flush_chk u_stg_flush (
         .uop_rob        (uop_q[g].robIdx),
         .redirect_valid (redirect_valid),
         .redirect_level (redirect_level),
         .redirect_rob   (redirect_rob),
         .flush          (stg_flush[g])
      );
   end

   // Global stall: the whole pipe moves only when the output slot can be vacated
   assign advance  = ~vld_q[LATENCY-1] | out_ready;
   assign in_ready = advance;
   assign stage_en = {LATENCY{advance}};

   always_comb begin
      vld_d    = vld_q;
      uop_d    = uop_q;
      data_d   = data_q;
      fflags_d = fflags_q;
      if (advance) begin
         // Flush is applied to each uop as it moves, so a squashed uop lands as a bubble
         vld_d[0] = in_valid & ~in_flush;
         uop_d[0] = in_uop;
         for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1] & ~stg_flush[i-1];
            uop_d[i] = uop_q[i-1];
         end
         data_d   = res_data;
         fflags_d = res_fflags;
      end else begin
         // Stalled: payload holds, but flushed uops still drop out in place
         vld_d = vld_q & ~stg_flush;
      end
   end

   // Stage registers: only the valid bits are reset
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   always_ff @(posedge clock) begin
      uop_q    <= uop_d;
      data_q   <= data_d;
      fflags_q <= fflags_d;
   end

   // Output register is the last stage
   assign out_valid        = vld_q[LATENCY-1];
   assign out_rfWen        = uop_q[LATENCY-1].rfWen;
   assign out_fpWen        = uop_q[LATENCY-1].fpWen;
   assign out_pdest        = uop_q[LATENCY-1].pdest[PDEST_W-1:0];
   assign out_robIdx_flag  = uop_q[LATENCY-1].robIdx.flag;
   assign out_robIdx_value = uop_q[LATENCY-1].robIdx.value[ROB_W-1:0];
   assign out_data         = data_q;
   assign out_fflags       = fflags_q;

endmodule

// File: doc/fma_uop_pipe.md
FMA_UOP_PIPE -- requirements
Module: fma_uop_pipe

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from input accept to out_valid with no stall; legal range 1..8.
REQ-002 SHALL have parameter ROB_W, default 5: ROB index value width.
REQ-003 SHALL have parameter PDEST_W, default 6: physical destination width.
REQ-004 SHALL have port clock, in, 1: sole clock.
REQ-005 SHALL have port reset, in, 1: synchronous, active-high.
REQ-006 SHALL have port in_valid / in_ready, in / out, 1 each: uop handshake.
REQ-007 SHALL have port in_rfWen, in_fpWen, in, 1 each: writeback enables.
REQ-008 SHALL have port in_rm, in, 3: static rounding mode; 3'h7 means dynamic.
REQ-009 SHALL have port in_pdest, in, PDEST_W.
REQ-010 SHALL have port in_robIdx_flag, in, 1, and in_robIdx_value, in, ROB_W.
REQ-011 SHALL have port frm, in, 3: CSR dynamic rounding mode.
REQ-012 SHALL have port rm_out, out, 3: resolved rounding mode for the input-stage datapath.
REQ-013 SHALL have port redirect_valid, redirect_robIdx_flag, redirect_level, in, 1 each, and redirect_robIdx_value, in, ROB_W.
REQ-014 SHALL have port stage_en, out, LATENCY: bit i high means stage i register loads this cycle; the external datapath uses it in lockstep.
REQ-015 SHALL have port res_data, in, 64, and res_fflags, in, 5: datapath result aligned with stage LATENCY-1.
REQ-016 SHALL have port out_valid / out_ready, out / in, 1 each: result handshake.
REQ-017 SHALL have port out_rfWen, out_fpWen, out_pdest, out_robIdx_flag, out_robIdx_value, out_data (64), out_fflags (5), out: registered result uop.

Function
REQ-018 rm_out SHALL equal in_rm when in_rm != 3'h7, else frm (combinational).
REQ-019 Pipeline SHALL hold LATENCY stage registers: valid bit, uop fields, and resolved rm; the last stage also captures res_data/res_fflags.
REQ-020 advance SHALL equal ~out_valid | out_ready; all stages load together iff advance (global stall); stage_en = {LATENCY{advance}}.
REQ-021 in_ready SHALL equal advance; a uop is accepted when in_valid & in_ready.
REQ-022 flush(u) SHALL be true iff redirect_valid & (isAfter(u, redirect) | (redirect_level & u.robIdx == redirect.robIdx)); isAfter(a,b) = (a.flag ^ b.flag) ^ (a.value > b.value).
REQ-023 An accepted uop with flush true SHALL enter stage 0 as invalid.
REQ-024 Any stage (output register included) whose uop is flushed SHALL become invalid next cycle, regardless of advance.
REQ-025 Unstalled latency SHALL be exactly LATENCY cycles: accept in cycle t gives out_valid in cycle t+LATENCY.
REQ-026 During a stall (out_valid & ~out_ready) every stage and all outputs SHALL hold their values.
REQ-027 Sustained in_valid with out_ready high SHALL give throughput of one uop per cycle.
REQ-028 Bubbles SHALL propagate without compaction; order is strictly FIFO.
REQ-029 A redirect arriving in the same cycle as accept and advance SHALL be applied to both the incoming and the advancing uops.

Reset
REQ-030 While reset is high, all stage valid bits and out_valid SHALL clear at the next clock edge; payload registers are not reset.
REQ-031 Reset mid-operation SHALL discard all in-flight uops; in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Package fma_pipe_pkg SHALL hold the uop struct (rfWen, fpWen, pdest, robIdx, rm), RM_DYN = 3'h7, and the isAfter function.
REQ-033 Sub-module fma_flush_chk (combinational, one uop robIdx vs redirect -> flush) SHALL be instantiated once per stage plus once for the input.

Verification
REQ-034 LATENCY=3, out_ready=1: accept robIdx 5 at cycle 10 -> out_valid cycle 13, out_robIdx_value=5, out_data=res_data sampled at cycle 12.
REQ-035 in_rm=7, frm=3'b010 -> rm_out=2; in_rm=3'b001 -> rm_out=1, carried unchanged to the output stage.
REQ-036 Stages hold robIdx 4,5,6; redirect robIdx 5, level=0 -> only 6 is dropped; level=1 -> 5 and 6 are dropped; 4 still emerges.
REQ-037 Wrap: uop (flag=1, value=2), redirect (flag=0, value=30) -> uop is after the redirect and is flushed.
REQ-038 out_ready low for 4 cycles with full pipe -> in_ready=0, stage_en=0, outputs stable; then 3 back-to-back results.
REQ-039 Assert reset one cycle with 3 uops in flight -> no out_valid afterwards; in_ready=1.
